morse_tx_scheduler: RTL and testbench

- Message-level sequencer for Mode 0 (Alphabet->Morse): buffers confirmed keypad characters in a FIFO.
- Presents characters one at a time to the morse_encoder/buzzer_driver pair and inserts standard Morse inter-character and inter-word gaps.
- Sits between keypad_decoder (producer) and the buzzer path (consumer) and replaces direct keypad_valid->start wiring, so characters typed while the buzzer is sounding are not lost.

---
 rtl/morse_tx_scheduler.sv | 265 ++++++++++++++++++++++++++
 tb/tb_morse_tx_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_tx_scheduler.sv
// morse_tx_scheduler
//
// Message-level sequencer for Mode 0 (Alphabet->Morse). Confirmed keypad
// characters are buffered in a FIFO and handed one at a time to the
// morse_encoder/buzzer_driver pair. The scheduler inserts the standard
// Morse silences: CHAR_GAP dot units after every sounded letter, and a
// space character stretches that silence to WORD_GAP units in total.
//
// Ports:
//   clk        in   system clock (1 MHz)
//   rst        in   synchronous, active-high reset
//   unit_tick  in   one-clk strobe per Morse dot unit
//   enable     in   mode gate; 0 stops new characters from being started
//   abort      in   one-clk pulse; flush FIFO, clear overflow, back to IDLE
//   char_in    in   ASCII code from keypad_decoder
//   char_push  in   one-clk pulse; write char_in into the FIFO
//   buz_busy   in   buzzer_driver busy flag
//   char_out   out  ASCII to morse_encoder, held from START until next pop
//   buz_start  out  one-clk start pulse to buzzer_driver
//   sched_busy out  scheduler is not IDLE
//   fifo_count out  number of stored entries
//   fifo_full  out  FIFO holds DEPTH entries
//   fifo_empty out  FIFO holds no entries
//   overflow   out  sticky; a push was dropped because the FIFO was full
//   ack_err    out  (ACK_TIMEOUT_EN only) sticky; buzzer never went busy
//
// Optional feature macro: ACK_TIMEOUT_EN
//   When defined, a character whose start pulse is not acknowledged by
//   buz_busy within four cycles is skipped and ack_err is raised.
//   When undefined, WAIT_ACK waits forever and ack_err does not exist.

module morse_tx_scheduler #(
    parameter int DEPTH    = 16,
    parameter int CHAR_GAP = 3,
    parameter int WORD_GAP = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     unit_tick,
    input  logic                     enable,
    input  logic                     abort,
    input  logic [7:0]               char_in,
    input  logic                     char_push,
    input  logic                     buz_busy,
    output logic [7:0]               char_out,
    output logic                     buz_start,
    output logic                     sched_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     fifo_empty,
`ifdef ACK_TIMEOUT_EN
    output logic                     ack_err,
`endif
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = $clog2(WORD_GAP + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [GAP_W-1:0] CHAR_TGT = GAP_W'(CHAR_GAP);
    // A space follows a letter whose CHAR_GAP has already elapsed, so it
    // only needs to add the remainder of the word gap.
    localparam logic [GAP_W-1:0] WORD_TGT = GAP_W'(WORD_GAP - CHAR_GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t             state_q,   state_d;
    logic [PTR_W-1:0]   rd_ptr_q,  rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q,  wr_ptr_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         char_out_q, char_out_d;
    logic               buz_start_q, buz_start_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [GAP_W-1:0]   gap_tgt_q, gap_tgt_d;
`ifdef ACK_TIMEOUT_EN
    logic [2:0]         ack_cnt_q, ack_cnt_d;
    logic               ack_err_q, ack_err_d;
    // START plus three WAIT_ACK cycles gives four cycles without busy.
    localparam logic [2:0] ACK_LIMIT = 3'd2;
`endif

    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         head;
    logic               is_full;
    logic               is_empty;
    logic               push_ok;
    logic               pop;

    assign head     = mem_q[rd_ptr_q];
    assign is_full  = (count_q == FULL_CNT);
    assign is_empty = (count_q == '0);

    // Next-state logic for the sequencer FSM and the FIFO bookkeeping.
    // The FSM decides whether the head is popped this cycle; a push into a
    // full FIFO is still accepted when that pop frees a slot. abort is
    // applied last so it overrides everything except char_out.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        char_out_d  = char_out_q;
        buz_start_d = 1'b0;
        gap_cnt_d   = gap_cnt_q;
        gap_tgt_d   = gap_tgt_q;
`ifdef ACK_TIMEOUT_EN
        ack_cnt_d   = ack_cnt_q;
        ack_err_d   = ack_err_q;
`endif
        pop         = 1'b0;
        push_ok     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && !is_empty) begin
                    pop        = 1'b1;
                    char_out_d = head;
                    if ((head >= 8'h41) && (head <= 8'h5A)) begin
                        state_d     = S_START;
                        buz_start_d = 1'b1;
                    end else if (head == 8'h20) begin
                        state_d   = S_GAP;
                        gap_tgt_d = WORD_TGT;
                        gap_cnt_d = '0;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT_ACK;
`ifdef ACK_TIMEOUT_EN
                ack_cnt_d = 3'd0;
`endif
            end
            S_WAIT_ACK: begin
                if (buz_busy) begin
                    state_d = S_WAIT_DONE;
                end
`ifdef ACK_TIMEOUT_EN
                else if (ack_cnt_q == ACK_LIMIT) begin
                    state_d   = S_GAP;
                    gap_tgt_d = CHAR_TGT;
                    gap_cnt_d = '0;
                    ack_err_d = 1'b1;
                end else begin
                    ack_cnt_d = ack_cnt_q + 3'd1;
                end
`endif
            end
            S_WAIT_DONE: begin
                if (!buz_busy) begin
                    state_d   = S_GAP;
                    gap_tgt_d = CHAR_TGT;
                    gap_cnt_d = '0;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == gap_tgt_q) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = '0;
                end else if (unit_tick) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        push_ok = char_push && (!is_full || pop);
        if (char_push && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (abort) begin
            push_ok     = 1'b0;
            pop         = 1'b0;
            state_d     = S_IDLE;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            char_out_d  = char_out_q;
            buz_start_d = 1'b0;
            gap_cnt_d   = '0;
`ifdef ACK_TIMEOUT_EN
            ack_cnt_d   = 3'd0;
            ack_err_d   = 1'b0;
`endif
        end
    end

    // State and registered outputs. Reset wins over everything on the same
    // edge, so a pending start pulse is cut.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            char_out_q  <= 8'h00;
            buz_start_q <= 1'b0;
            gap_cnt_q   <= '0;
            gap_tgt_q   <= '0;
`ifdef ACK_TIMEOUT_EN
            ack_cnt_q   <= 3'd0;
            ack_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            char_out_q  <= char_out_d;
            buz_start_q <= buz_start_d;
            gap_cnt_q   <= gap_cnt_d;
            gap_tgt_q   <= gap_tgt_d;
`ifdef ACK_TIMEOUT_EN
            ack_cnt_q   <= ack_cnt_d;
            ack_err_q   <= ack_err_d;
`endif
        end
    end

    // FIFO storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= char_in;
        end
    end

    assign char_out   = char_out_q;
    assign buz_start  = buz_start_q;
    assign sched_busy = (state_q != S_IDLE);
    assign fifo_count = count_q;
    assign fifo_full  = is_full;
    assign fifo_empty = is_empty;
    assign overflow   = overflow_q;
`ifdef ACK_TIMEOUT_EN
    assign ack_err    = ack_err_q;
`endif

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// tb_morse_tx_scheduler
//
// Directed bench for morse_tx_scheduler. Letters expected to be sounded
// are queued when pushed; every buz_start pulse pops the queue and
// compares char_out. Inputs change on the falling edge, outputs are
// sampled on the falling edge.

module tb_morse_tx_scheduler;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       unit_tick;
    logic       enable;
    logic       abort;
    logic [7:0] char_in;
    logic       char_push;
    logic       buz_busy;
    logic [7:0] char_out;
    logic       buz_start;
    logic       sched_busy;
    logic [4:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;
`ifdef ACK_TIMEOUT_EN
    logic       ack_err;
`endif

    int         checks = 0;
    int         errors = 0;
    int         start_count = 0;
    int         base;
    logic [7:0] sb [$];
    logic [7:0] mon_exp;

    morse_tx_scheduler #(.DEPTH(DEPTH), .CHAR_GAP(3), .WORD_GAP(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .unit_tick  (unit_tick),
        .enable     (enable),
        .abort      (abort),
        .char_in    (char_in),
        .char_push  (char_push),
        .buz_busy   (buz_busy),
        .char_out   (char_out),
        .buz_start  (buz_start),
        .sched_busy (sched_busy),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
`ifdef ACK_TIMEOUT_EN
        .ack_err    (ack_err),
`endif
        .overflow   (overflow)
    );

    // 1 MHz system clock.
    always #500 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle push; letters that must later be sounded go to the scoreboard.
    task automatic applyStimulus(input logic [7:0] c, input bit expect_start);
        char_in   = c;
        char_push = 1'b1;
        if (expect_start) sb.push_back(c);
        step(1);
        char_push = 1'b0;
    endtask

    // Dot-unit strobes spaced so the FSM can pass through IDLE between gaps.
    task automatic sendTicks(input int n);
        repeat (n) begin
            unit_tick = 1'b1;
            step(1);
            unit_tick = 1'b0;
            step(3);
        end
    endtask

    task automatic busyPulse(input int n);
        buz_busy = 1'b1;
        step(n);
        buz_busy = 1'b0;
    endtask

    task automatic waitStarts(input string tag, input int target, input int budget);
        int n = 0;
        while (start_count < target && n < budget) begin
            step(1);
            n++;
        end
        checkOutput(tag, start_count, target);
    endtask

    // Scoreboard consumer: each start pulse must match the next queued letter.
    always @(negedge clk) begin
        if (!rst && buz_start === 1'b1) begin
            start_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_buz_start", 32'd1, 32'd0);
            end else begin
                mon_exp = sb.pop_front();
                checkOutput("char_out_at_start", char_out, mon_exp);
            end
        end
    end

    // Watchdog so a stuck FSM still ends the run.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        unit_tick = 1'b0;
        enable    = 1'b0;
        abort     = 1'b0;
        char_in   = 8'h00;
        char_push = 1'b0;
        buz_busy  = 1'b0;
        step(3);
        checkOutput("rst_char_out",   char_out,   8'h00);
        checkOutput("rst_buz_start",  buz_start,  1'b0);
        checkOutput("rst_sched_busy", sched_busy, 1'b0);
        checkOutput("rst_fifo_count", fifo_count, 5'd0);
        checkOutput("rst_fifo_full",  fifo_full,  1'b0);
        checkOutput("rst_fifo_empty", fifo_empty, 1'b1);
        checkOutput("rst_overflow",   overflow,   1'b0);
        rst = 1'b0;
        step(1);

        $display("[TB] single letter S");
        enable = 1'b1;
        applyStimulus(8'h53, 1'b1);
        checkOutput("s_count_after_push", fifo_count, 5'd1);
        checkOutput("s_no_start_yet",     buz_start,  1'b0);
        step(1);
        checkOutput("s_char_out_pop", char_out,   8'h53);
        checkOutput("s_start_high",   buz_start,  1'b1);
        checkOutput("s_fifo_empty",   fifo_empty, 1'b1);
        step(1);
        checkOutput("s_start_one_cycle", buz_start,  1'b0);
        checkOutput("s_busy_running",    sched_busy, 1'b1);
        busyPulse(20);
        step(2);
        sendTicks(2);
        checkOutput("s_busy_after_2_ticks", sched_busy, 1'b1);
        sendTicks(1);
        checkOutput("s_idle_after_3_ticks", sched_busy, 1'b0);

        $display("[TB] word gap A space B");
        base = start_count;
        applyStimulus(8'h41, 1'b1);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h42, 1'b1);
        waitStarts("start_A", base + 1, 5);
        busyPulse(5);
        step(2);
        sendTicks(6);
        checkOutput("no_start_for_space", start_count, base + 1);
        checkOutput("busy_in_word_gap",   sched_busy,  1'b1);
        sendTicks(1);
        waitStarts("start_B_after_7_ticks", base + 2, 5);
        busyPulse(3);
        step(2);
        sendTicks(3);
        checkOutput("ab_idle",  sched_busy, 1'b0);
        checkOutput("ab_empty", fifo_empty, 1'b1);

        $display("[TB] non-letter discard");
        base = start_count;
        applyStimulus(8'h35, 1'b0);
        applyStimulus(8'h45, 1'b1);
        checkOutput("discard_no_start", buz_start,  1'b0);
        checkOutput("discard_idle",     sched_busy, 1'b0);
        checkOutput("discard_count",    fifo_count, 5'd1);
        step(1);
        checkOutput("e_start_after_discard", buz_start, 1'b1);
        busyPulse(3);
        step(2);
        sendTicks(3);
        checkOutput("e_done", start_count, base + 1);

        $display("[TB] overflow");
        enable = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(8'(8'h41 + i), i == 0);
        end
        checkOutput("ovf_full",     fifo_full,  1'b1);
        checkOutput("ovf_count",    fifo_count, 5'd16);
        checkOutput("ovf_sticky",   overflow,   1'b1);
        checkOutput("ovf_not_busy", sched_busy, 1'b0);
        enable    = 1'b1;
        char_in   = 8'h5A;
        char_push = 1'b1;
        step(1);
        char_push = 1'b0;
        enable    = 1'b0;
        checkOutput("pushpop_count", fifo_count, 5'd16);
        checkOutput("pushpop_full",  fifo_full,  1'b1);
        checkOutput("pushpop_ovf",   overflow,   1'b1);
        checkOutput("pushpop_start", buz_start,  1'b1);
        step(1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checkOutput("abort_clears_ovf",   overflow,   1'b0);
        checkOutput("abort_empties_fifo", fifo_empty, 1'b1);
        checkOutput("abort_to_idle",      sched_busy, 1'b0);

        $display("[TB] abort during WAIT_DONE");
        enable = 1'b1;
        base = start_count;
        applyStimulus(8'h54, 1'b1);
        buz_busy = 1'b1;
        applyStimulus(8'h4D, 1'b0);
        applyStimulus(8'h4F, 1'b0);
        applyStimulus(8'h52, 1'b0);
        applyStimulus(8'h53, 1'b0);
        applyStimulus(8'h45, 1'b0);
        checkOutput("wd_queued",  fifo_count, 5'd5);
        checkOutput("wd_busy",    sched_busy, 1'b1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checkOutput("wd_abort_empty", fifo_empty, 1'b1);
        checkOutput("wd_abort_count", fifo_count, 5'd0);
        checkOutput("wd_abort_ovf",   overflow,   1'b0);
        checkOutput("wd_abort_idle",  sched_busy, 1'b0);
        checkOutput("wd_char_kept",   char_out,   8'h54);
        step(3);
        buz_busy = 1'b0;
        step(3);
        sendTicks(3);
        checkOutput("wd_no_later_start", start_count, base + 1);
        checkOutput("wd_still_idle",     sched_busy,  1'b0);
        abort     = 1'b1;
        char_in   = 8'h51;
        char_push = 1'b1;
        step(1);
        abort     = 1'b0;
        char_push = 1'b0;
        checkOutput("abort_push_dropped", fifo_empty, 1'b1);
        checkOutput("abort_push_no_ovf",  overflow,   1'b0);
        step(3);
        checkOutput("abort_push_no_start", start_count, base + 1);
        applyStimulus(8'h45, 1'b1);
        step(2);
        checkOutput("new_push_starts", start_count, base + 2);
        busyPulse(2);
        step(2);
        sendTicks(3);
        checkOutput("new_push_done", sched_busy, 1'b0);

`ifdef ACK_TIMEOUT_EN
        $display("[TB] ack timeout");
        base = start_count;
        applyStimulus(8'h47, 1'b1);
        applyStimulus(8'h48, 1'b1);
        checkOutput("to_start_G", buz_start, 1'b1);
        step(3);
        checkOutput("to_no_err_yet", ack_err, 1'b0);
        step(1);
        checkOutput("to_err_set", ack_err,    1'b1);
        checkOutput("to_in_gap",  sched_busy, 1'b1);
        sendTicks(3);
        waitStarts("to_start_H", base + 2, 5);
        step(8);
        sendTicks(3);
        checkOutput("to_idle",       sched_busy, 1'b0);
        checkOutput("to_err_sticky", ack_err,    1'b1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checkOutput("to_err_cleared", ack_err, 1'b0);
`endif

        $display("[TB] reset mid-operation");
        applyStimulus(8'h4B, 1'b0);
        rst = 1'b1;
        step(1);
        checkOutput("midrst_no_start", buz_start,  1'b0);
        checkOutput("midrst_empty",    fifo_empty, 1'b1);
        checkOutput("midrst_char_out", char_out,   8'h00);
        checkOutput("midrst_idle",     sched_busy, 1'b0);
        rst = 1'b0;
        step(3);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
